dff_pipeline: RTL

DFF_PIPELINE -- requirements
Module: dff_pipeline

---
 rtl/dff_pkg.sv | 22 ++
 rtl/pipe_stage.sv | 53 +++++
 rtl/dff_pipeline.sv | 69 ++++++
 3 files changed

// File: rtl/dff_pkg.sv
// Shared defaults and helpers for the register pipeline.
//   WIDTH_DEF   : default data bits per stage
//   STAGES_DEF  : default number of register stages
//   RST_VAL_DEF : default data value loaded on reset/flush
//   clog2()     : ceiling log2, used to size the occupancy count
package dff_pkg;

  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned STAGES_DEF = 4;
  localparam logic [WIDTH_DEF-1:0] RST_VAL_DEF = '0;

  // Smallest r such that 2**r >= value (0 for value <= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a data register plus its valid flag.
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset (data <- RST_VAL, valid <- 0)
//   en      : 1 = load (d, d_valid) this edge, 0 = hold
//   flush   : synchronous clear, takes priority over en
//   d       : data in
//   d_valid : valid in
//   q       : registered data out
//   q_valid : registered valid out
module pipe_stage #(
  parameter int unsigned        WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      data_d  = RST_VAL;
      valid_d = 1'b0;
    end else if (en) begin
      // Bubbles still carry their data bits; only the flag marks them empty.
      data_d  = d;
      valid_d = d_valid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= RST_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q       = data_q;
  assign q_valid = valid_q;

endmodule

// File: rtl/dff_pipeline.sv
// Parameterised register pipeline with valid tracking.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   en        : advance enable (1 = shift, 0 = hold)
//   flush     : synchronous clear of every stage, priority over en
//   d/d_valid : data and qualifier into stage 0
//   q/q_valid : data and valid of the last stage
//   taps      : all stage data, stage i at [i*WIDTH +: WIDTH]
//   occupancy : number of stages currently holding valid data
module dff_pipeline
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH   = WIDTH_DEF,
  parameter int unsigned      STAGES  = STAGES_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(RST_VAL_DEF)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             flush,
  input  logic [WIDTH-1:0]                 d,
  input  logic                             d_valid,
  output logic [WIDTH-1:0]                 q,
  output logic                             q_valid,
  output logic [WIDTH*STAGES-1:0]          taps,
  output logic [clog2(STAGES+1)-1:0]       occupancy
);

  localparam int unsigned OCC_W = clog2(STAGES + 1);

  // Chain index 0 is the pipeline input; index i+1 is the output of stage i.
  logic [WIDTH-1:0] data_chain [STAGES+1];
  logic [STAGES:0]  valid_chain;

  assign data_chain[0]  = d;
  assign valid_chain[0] = d_valid;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .flush   (flush),
      .d       (data_chain[g]),
      .d_valid (valid_chain[g]),
      .q       (data_chain[g+1]),
      .q_valid (valid_chain[g+1])
    );
    assign taps[g*WIDTH +: WIDTH] = data_chain[g+1];
  end

  assign q       = data_chain[STAGES];
  assign q_valid = valid_chain[STAGES];

  logic [OCC_W-1:0] occ_sum;

  always_comb begin
    occ_sum = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      occ_sum = occ_sum + OCC_W'(valid_chain[i+1]);
    end
  end

  assign occupancy = occ_sum;

endmodule
